// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter that funnels three byte producers into one TX FIFO.
// A grant is held until the owner's last byte, or until the owner sits idle for TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [7:0] req_data2,
  input  logic [2:0] req_last,
  output logic [2:0] req_ready,
  input  logic       fifo_full,
  output logic [7:0] fifo_wdata,
  output logic       fifo_wr,
  output logic [1:0] owner,
  output logic       timeout_err
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [16:0] CNT_LAST = 17'(TIMEOUT_CYC - 1);
  localparam logic [1:0]  NO_OWNER = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [16:0] cnt_q, cnt_d;

  logic        own_valid, own_last, grant, xfer, expired;
  logic [7:0]  own_data;
  logic [2:0]  own_sel;

  // Search starts one past the previously served requester.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] vld);
    case (last)
      2'd0:    rr_pick = vld[1] ? 2'd1 : (vld[2] ? 2'd2 : 2'd0);
      2'd1:    rr_pick = vld[2] ? 2'd2 : (vld[0] ? 2'd0 : 2'd1);
      default: rr_pick = vld[0] ? 2'd0 : (vld[1] ? 2'd1 : 2'd2);
    endcase
  endfunction

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    own_sel   = 3'b000;
    case (owner_q)
      2'd0: begin own_valid = req_valid[0]; own_last = req_last[0]; own_data = req_data0; own_sel = 3'b001; end
      2'd1: begin own_valid = req_valid[1]; own_last = req_last[1]; own_data = req_data1; own_sel = 3'b010; end
      2'd2: begin own_valid = req_valid[2]; own_last = req_last[2]; own_data = req_data2; own_sel = 3'b100; end
      default: ;
    endcase
  end

  assign grant       = (state_q == LOCK);
  assign xfer        = grant & ~fifo_full & own_valid;
  assign expired     = grant & ~xfer & (cnt_q == CNT_LAST);
  assign req_ready   = (grant && !fifo_full) ? own_sel : 3'b000;
  assign fifo_wr     = xfer;
  assign fifo_wdata  = xfer ? own_data : 8'h00;
  assign owner       = owner_q;
  assign timeout_err = expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= NO_OWNER;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = LOCK;
          owner_d = rr_pick(last_q, req_valid);
          cnt_d   = '0;
        end
      end
      LOCK: begin
        // A transfer always beats an expiring counter in the same cycle.
        if (xfer) begin
          cnt_d = '0;
          if (own_last) begin
            state_d = IDLE;
            owner_d = NO_OWNER;
            last_d  = owner_q;
          end
        end else if (expired) begin
          state_d = IDLE;
          owner_d = NO_OWNER;
          last_d  = owner_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: dut_a uses the default timeout, dut_b uses TIMEOUT_CYC=16 for the timeout cases.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req_valid;
  logic [7:0] req_data0, req_data1, req_data2;
  logic [2:0] req_last;
  logic       fifo_full;

  logic [2:0] ready_a, ready_b;
  logic [7:0] wdata_a, wdata_b;
  logic       wr_a, wr_b;
  logic [1:0] owner_a, owner_b;
  logic       terr_a, terr_b;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
    .req_last(req_last), .req_ready(ready_a), .fifo_full(fifo_full),
    .fifo_wdata(wdata_a), .fifo_wr(wr_a), .owner(owner_a), .timeout_err(terr_a)
  );

  uart_tx_arbiter #(.TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
    .req_last(req_last), .req_ready(ready_b), .fifo_full(fifo_full),
    .fifo_wdata(wdata_b), .fifo_wr(wr_b), .owner(owner_b), .timeout_err(terr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 3'b000;
    req_last  = 3'b000;
    req_data0 = 8'h00;
    req_data1 = 8'h00;
    req_data2 = 8'h00;
    fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          idx [3];
    logic        acc [3];
    logic [7:0]  base [3];
    int          n, ph, r, rnd;
    logic [1:0]  e_own;
    logic [7:0]  e_dat;
    logic        e_wr;

    base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0;

    // Reset values
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_owner_a", owner_a, 2'd3);
    chk("rst_ready_a", ready_a, 3'b000);
    chk("rst_wr_a", wr_a, 1'b0);
    chk("rst_wdata_a", wdata_a, 8'h00);
    chk("rst_terr_a", terr_a, 1'b0);
    chk("rst_owner_b", owner_b, 2'd3);
    @(negedge clk);
    rst = 1'b0;

    // Single-byte message from requester 0
    @(negedge clk);
    req_valid = 3'b001; req_data0 = 8'h52; req_last = 3'b001;
    #1;
    chk("single_dead_owner", owner_a, 2'd3);
    chk("single_dead_ready", ready_a, 3'b000);
    chk("single_dead_wr", wr_a, 1'b0);
    @(negedge clk);
    #1;
    chk("single_owner", owner_a, 2'd0);
    chk("single_ready", ready_a, 3'b001);
    chk("single_wr", wr_a, 1'b1);
    chk("single_wdata", wdata_a, 8'h52);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("single_release_owner", owner_a, 2'd3);
    chk("single_release_wr", wr_a, 1'b0);
    chk("single_release_wdata", wdata_a, 8'h00);

    // Three requesters, 3-byte messages each, all valid continuously
    do_reset();
    for (int i = 0; i < 3; i++) begin idx[i] = 0; acc[i] = 1'b0; end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (acc[i]) idx[i]++;
      req_valid = 3'b111;
      req_data0 = 8'(base[0] + idx[0]);
      req_data1 = 8'(base[1] + idx[1]);
      req_data2 = 8'(base[2] + idx[2]);
      req_last  = {idx[2] % 3 == 2, idx[1] % 3 == 2, idx[0] % 3 == 2};
      #1;
      n = c / 4; ph = c % 4;
      if (ph == 0) begin
        e_wr = 1'b0; e_own = 2'd3; e_dat = 8'h00;
      end else begin
        r = n % 3; rnd = n / 3;
        e_wr = 1'b1; e_own = 2'(r); e_dat = 8'(base[r] + 3 * rnd + ph - 1);
      end
      chk($sformatf("rr_owner_c%0d", c), owner_a, e_own);
      chk($sformatf("rr_wr_c%0d", c), wr_a, e_wr);
      chk($sformatf("rr_wdata_c%0d", c), wdata_a, e_dat);
      for (int i = 0; i < 3; i++) acc[i] = ready_a[i] & req_valid[i];
    end

    // Requester 1 stalled by a full FIFO mid-message
    do_reset();
    @(negedge clk);
    req_valid = 3'b010; req_data1 = 8'h61; req_last = 3'b000;
    #1;
    chk("full_dead_owner", owner_a, 2'd3);
    @(negedge clk);
    #1;
    chk("full_first_wr", wr_a, 1'b1);
    chk("full_first_wdata", wdata_a, 8'h61);
    @(negedge clk);
    req_data1 = 8'h62; fifo_full = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk($sformatf("full_ready_c%0d", c), ready_a, 3'b000);
      chk($sformatf("full_wr_c%0d", c), wr_a, 1'b0);
      chk($sformatf("full_owner_c%0d", c), owner_a, 2'd1);
      chk($sformatf("full_terr_c%0d", c), terr_a, 1'b0);
      @(negedge clk);
    end
    fifo_full = 1'b0;
    #1;
    chk("full_resume_wr", wr_a, 1'b1);
    chk("full_resume_wdata", wdata_a, 8'h62);
    chk("full_resume_ready", ready_a, 3'b010);
    @(negedge clk);
    req_data1 = 8'h63; req_last = 3'b010;
    #1;
    chk("full_last_wr", wr_a, 1'b1);
    chk("full_last_wdata", wdata_a, 8'h63);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("full_done_owner", owner_a, 2'd3);
    chk("full_done_terr", terr_a, 1'b0);

    // Timeout of requester 2 with requester 0 pending (TIMEOUT_CYC=16)
    do_reset();
    @(negedge clk);
    req_valid = 3'b100; req_data2 = 8'hD1; req_last = 3'b000;
    #1;
    chk("to_dead_owner", owner_b, 2'd3);
    @(negedge clk);
    #1;
    chk("to_byte_owner", owner_b, 2'd2);
    chk("to_byte_wr", wr_b, 1'b1);
    chk("to_byte_wdata", wdata_b, 8'hD1);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      req_valid = 3'b001; req_data0 = 8'h30; req_last = 3'b001; req_data2 = 8'h00;
      #1;
      chk($sformatf("to_wait_terr_c%0d", c), terr_b, 1'b0);
      chk($sformatf("to_wait_owner_c%0d", c), owner_b, 2'd2);
      chk($sformatf("to_wait_wr_c%0d", c), wr_b, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("to_pulse_terr", terr_b, 1'b1);
    chk("to_pulse_owner", owner_b, 2'd2);
    @(negedge clk);
    #1;
    chk("to_after_terr", terr_b, 1'b0);
    chk("to_after_owner", owner_b, 2'd3);
    chk("to_after_ready", ready_b, 3'b000);
    @(negedge clk);
    #1;
    chk("to_next_owner", owner_b, 2'd0);
    chk("to_next_wr", wr_b, 1'b1);
    chk("to_next_wdata", wdata_b, 8'h30);
    @(negedge clk);
    idle_inputs();

    // Transfer coinciding with the final counter value keeps the grant
    do_reset();
    @(negedge clk);
    req_valid = 3'b100; req_data2 = 8'hC0; req_last = 3'b000;
    @(negedge clk);
    #1;
    chk("tie_first_wr", wr_b, 1'b1);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      req_valid = 3'b000;
    end
    @(negedge clk);
    req_valid = 3'b100; req_data2 = 8'hC1;
    #1;
    chk("tie_wr", wr_b, 1'b1);
    chk("tie_wdata", wdata_b, 8'hC1);
    chk("tie_terr", terr_b, 1'b0);
    chk("tie_owner", owner_b, 2'd2);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("tie_kept_owner", owner_b, 2'd2);
    chk("tie_kept_terr", terr_b, 1'b0);
    for (int c = 0; c < 15; c++) @(negedge clk);
    #1;
    chk("tie_restart_terr", terr_b, 1'b1);

    // Reset in the middle of a 4-byte message from requester 1
    do_reset();
    @(negedge clk);
    req_valid = 3'b010; req_data1 = 8'h71; req_last = 3'b000;
    @(negedge clk);
    #1;
    chk("mid_b1_wdata", wdata_a, 8'h71);
    @(negedge clk);
    req_data1 = 8'h72;
    #1;
    chk("mid_b2_wr", wr_a, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_owner", owner_a, 2'd3);
    chk("mid_rst_ready", ready_a, 3'b000);
    chk("mid_rst_wr", wr_a, 1'b0);
    chk("mid_rst_wdata", wdata_a, 8'h00);
    chk("mid_rst_terr", terr_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mid_after_wr_c%0d", c), wr_a, 1'b0);
      chk($sformatf("mid_after_owner_c%0d", c), owner_a, 2'd3);
    end
    @(negedge clk);
    req_valid = 3'b010; req_data1 = 8'h75;
    #1;
    chk("mid_regrant_dead", wr_a, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_regrant_owner", owner_a, 2'd1);
    chk("mid_regrant_wdata", wdata_a, 8'h75);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
